gbsha_fir_core: RTL and testbench

Parametrised streaming FIR filter core, successor to the fixed 2-bit tapeout filter behind `gbsha_top`. It has:

- configurable sample, coefficient and output widths and tap count;
- run-time serially loadable coefficients;
- a sample-valid strobe and a two-stage multiply/accumulate pipeline;
- round-half-up plus saturation on the output, with a saturation flag.

`gbsha_top` instantiates it and maps its pins onto `io_in`/`io_out`.

---
 rtl/gbsha_fir_pkg.sv | 51 +++++
 rtl/gbsha_fir_round_sat.sv | 25 ++
 rtl/gbsha_fir_core.sv | 136 +++++++++++++
 tb/tb_gbsha_fir_core.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/gbsha_fir_pkg.sv
// Shared sizing and rounding/saturation helpers for the gbsha FIR core.
// sat_round works in 64 bits, so accumulators up to 63 bits wide are covered.
package gbsha_fir_pkg;

    typedef struct packed {
        logic signed [63:0] val;
        logic               clip;
    } sat_res_t;

    // Accumulator wide enough that the sum of NTAPS full products never overflows.
    function automatic int acc_width(input int xw, input int cw, input int ntaps);
        int lg;
        lg = (ntaps > 1) ? $clog2(ntaps) : 1;
        return xw + cw + lg;
    endfunction

    // Unity gain coefficient (1 << shift), clipped to the positive coefficient range.
    function automatic int coef_unit(input int shift, input int cw);
        int mx;
        int one;
        mx  = (1 << (cw - 1)) - 1;
        one = 1 << shift;
        return (one > mx) ? mx : one;
    endfunction

    function automatic sat_res_t sat_round(input logic signed [63:0] acc,
                                           input int shift, input int yw);
        logic signed [63:0] r;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        sat_res_t           res;
        r = acc;
        if (shift > 0) begin
            r = r + (64'sd1 <<< (shift - 1));
        end
        r  = r >>> shift;
        hi = (64'sd1 <<< (yw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (yw - 1));
        res.val  = r;
        res.clip = 1'b0;
        if (r > hi) begin
            res.val  = hi;
            res.clip = 1'b1;
        end else if (r < lo) begin
            res.val  = lo;
            res.clip = 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/gbsha_fir_round_sat.sv
// Combinational round-half-up, arithmetic shift and saturation of the accumulator.
module gbsha_fir_round_sat
    import gbsha_fir_pkg::*;
#(
    parameter int AW    = 8,
    parameter int SHIFT = 1,
    parameter int YW    = 2
) (
    input  logic signed [AW-1:0] i_acc,
    output logic signed [YW-1:0] o_y,
    output logic                 o_sat
);

    sat_res_t          w_res;
    logic [63-YW:0]    w_unused_hi;

    always_comb begin
        w_res = sat_round(64'(i_acc), SHIFT, YW);
    end

    // After clipping the upper bits are pure sign extension.
    assign {w_unused_hi, o_y} = w_res.val;
    assign o_sat              = w_res.clip;

endmodule

// File: rtl/gbsha_fir_core.sv
// Streaming FIR: delay line, serially loaded coefficients, registered products,
// then accumulate/round/saturate into the output register (2-cycle latency).
module gbsha_fir_core
    import gbsha_fir_pkg::*;
#(
    parameter int XW    = 2,
    parameter int CW    = 4,
    parameter int NTAPS = 4,
    parameter int YW    = 2,
    parameter int SHIFT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic signed [XW-1:0] x_in,
    input  logic                 x_valid,
    input  logic                 clr,
    input  logic                 coef_we,
    input  logic signed [CW-1:0] coef_data,
    output logic signed [YW-1:0] y_out,
    output logic                 y_valid,
    output logic                 y_sat
);

    localparam int AW = acc_width(XW, CW, NTAPS);
    localparam int PW = XW + CW;
    localparam logic signed [CW-1:0] C0_RST = CW'(coef_unit(SHIFT, CW));

    logic signed [XW-1:0] w_d [NTAPS];
    logic signed [CW-1:0] w_c [NTAPS];
    logic signed [PW-1:0] w_p [NTAPS];
    logic signed [AW-1:0] w_acc;
    logic signed [YW-1:0] w_y;
    logic                 w_sat;

    logic                 r_dv;
    logic                 r_vb;
    logic signed [YW-1:0] r_y;
    logic                 r_y_valid;
    logic                 r_y_sat;

    for (genvar k = 0; k < NTAPS; k++) begin : g_tap
        localparam logic signed [CW-1:0] C_RST = (k == 0) ? C0_RST : '0;

        logic signed [XW-1:0] r_d;
        logic signed [CW-1:0] r_c;
        logic signed [PW-1:0] r_p;
        logic signed [XW-1:0] w_d_prev;
        logic signed [CW-1:0] w_c_next;

        if (k == 0) begin : g_d_head
            assign w_d_prev = x_in;
        end else begin : g_d_body
            assign w_d_prev = w_d[k-1];
        end

        // Coefficients enter at the top tap and walk down towards c[0].
        if (k == NTAPS - 1) begin : g_c_head
            assign w_c_next = coef_data;
        end else begin : g_c_body
            assign w_c_next = w_c[k+1];
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_d <= '0;
            end else if (clr) begin
                r_d <= '0;
            end else if (x_valid) begin
                r_d <= w_d_prev;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_c <= C_RST;
            end else if (coef_we) begin
                r_c <= w_c_next;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_p <= '0;
            end else if (clr) begin
                r_p <= '0;
            end else begin
                r_p <= PW'(r_d) * PW'(r_c);
            end
        end

        assign w_d[k] = r_d;
        assign w_c[k] = r_c;
        assign w_p[k] = r_p;
    end

    always_comb begin
        w_acc = '0;
        for (int k = 0; k < NTAPS; k++) begin
            w_acc = w_acc + AW'(w_p[k]);
        end
    end

    gbsha_fir_round_sat #(
        .AW    (AW),
        .SHIFT (SHIFT),
        .YW    (YW)
    ) u_round_sat (
        .i_acc (w_acc),
        .o_y   (w_y),
        .o_sat (w_sat)
    );

    // r_dv tags the delay line, r_vb tags the product registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dv      <= 1'b0;
            r_vb      <= 1'b0;
            r_y       <= '0;
            r_y_valid <= 1'b0;
            r_y_sat   <= 1'b0;
        end else begin
            r_dv      <= x_valid & ~clr;
            r_vb      <= r_dv & ~clr;
            r_y_valid <= r_vb & ~clr;
            r_y_sat   <= r_vb & ~clr & w_sat;
            if (r_vb && !clr) begin
                r_y <= w_y;
            end
        end
    end

    assign y_out   = r_y;
    assign y_valid = r_y_valid;
    assign y_sat   = r_y_sat;

endmodule

// File: tb/tb_gbsha_fir_core.sv
// Directed bench for gbsha_fir_core: default instance (YW=2) and a YW=4 instance.
module tb_gbsha_fir_core;

    logic              clk;
    logic              rst;

    logic signed [1:0] x_a;
    logic              xv_a;
    logic              clr_a;
    logic              cwe_a;
    logic signed [3:0] cd_a;
    logic signed [1:0] y_a;
    logic              yv_a;
    logic              ys_a;

    logic signed [1:0] x_b;
    logic              xv_b;
    logic              clr_b;
    logic              cwe_b;
    logic signed [3:0] cd_b;
    logic signed [3:0] y_b;
    logic              yv_b;
    logic              ys_b;

    int n_checks;
    int n_errors;

    gbsha_fir_core u_dut (
        .clk       (clk),
        .rst       (rst),
        .x_in      (x_a),
        .x_valid   (xv_a),
        .clr       (clr_a),
        .coef_we   (cwe_a),
        .coef_data (cd_a),
        .y_out     (y_a),
        .y_valid   (yv_a),
        .y_sat     (ys_a)
    );

    gbsha_fir_core #(.YW(4)) u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .x_in      (x_b),
        .x_valid   (xv_b),
        .clr       (clr_b),
        .coef_we   (cwe_b),
        .coef_data (cd_b),
        .y_out     (y_b),
        .y_valid   (yv_b),
        .y_sat     (ys_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic load_a(input logic signed [3:0] c0, input logic signed [3:0] c1,
                          input logic signed [3:0] c2, input logic signed [3:0] c3);
        cwe_a = 1'b1;
        cd_a = c0; tick();
        cd_a = c1; tick();
        cd_a = c2; tick();
        cd_a = c3; tick();
        cwe_a = 1'b0;
        cd_a = '0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        x_a = '0; xv_a = 1'b0; clr_a = 1'b0; cwe_a = 1'b0; cd_a = '0;
        x_b = '0; xv_b = 1'b0; clr_b = 1'b0; cwe_b = 1'b0; cd_b = '0;
        tick();
        tick();
        chk("rst_y_out", y_a, 0);
        chk("rst_y_valid", yv_a, 0);
        chk("rst_y_sat", ys_a, 0);
        rst = 1'b0;

        // identity passthrough with reset coefficients
        x_a = 2'sd1; xv_a = 1'b1; tick();
        chk("id_lat0", yv_a, 0);
        x_a = -2'sd2; tick();
        chk("id_lat1", yv_a, 0);
        xv_a = 1'b0; tick();
        chk("id_v0", yv_a, 1);
        chk("id_y0", y_a, 1);
        chk("id_s0", ys_a, 0);
        tick();
        chk("id_v1", yv_a, 1);
        chk("id_y1", y_a, -2);
        tick();
        chk("id_v_end", yv_a, 0);
        chk("id_hold", y_a, -2);

        // YW=4 impulse response with coefficients 2,4,6,-2
        cwe_b = 1'b1;
        cd_b = 4'sd2; tick();
        cd_b = 4'sd4; tick();
        cd_b = 4'sd6; tick();
        cd_b = -4'sd2; tick();
        cwe_b = 1'b0; cd_b = '0;
        x_b = 2'sd1; xv_b = 1'b1; tick();
        x_b = 2'sd0; tick();
        tick();
        chk("imp_v0", yv_b, 1);
        chk("imp_y0", y_b, 1);
        chk("imp_s0", ys_b, 0);
        tick();
        chk("imp_y1", y_b, 2);
        tick();
        chk("imp_y2", y_b, 3);
        xv_b = 1'b0; tick();
        chk("imp_y3", y_b, -1);
        chk("imp_v3", yv_b, 1);
        tick();
        chk("imp_y4", y_b, 0);
        chk("imp_v4", yv_b, 1);
        tick();
        chk("imp_v_end", yv_b, 0);

        // saturation with all coefficients at 7
        load_a(4'sd7, 4'sd7, 4'sd7, 4'sd7);
        x_a = 2'sd1; xv_a = 1'b1;
        tick(); tick();
        tick();
        chk("sat_mid_y", y_a, 0);
        chk("sat_mid_s", ys_a, 0);
        tick();
        x_a = -2'sd2; tick();
        tick();
        chk("sat_pos_y", y_a, 1);
        chk("sat_pos_s", ys_a, 1);
        tick(); tick();
        xv_a = 1'b0; tick();
        tick();
        chk("sat_neg_y", y_a, -2);
        chk("sat_neg_s", ys_a, 1);
        chk("sat_neg_v", yv_a, 1);
        tick();
        chk("sat_clr_v", yv_a, 0);
        chk("sat_clr_s", ys_a, 0);
        chk("sat_hold_y", y_a, -2);

        // valid gap pattern 1,0,1,1 on identity coefficients
        load_a(4'sd2, 4'sd0, 4'sd0, 4'sd0);
        x_a = 2'sd1; xv_a = 1'b1; tick();
        xv_a = 1'b0; tick();
        x_a = -2'sd1; xv_a = 1'b1; tick();
        chk("gap_v0", yv_a, 1);
        chk("gap_y0", y_a, 1);
        x_a = -2'sd2; tick();
        chk("gap_v1", yv_a, 0);
        chk("gap_y1_hold", y_a, 1);
        xv_a = 1'b0; tick();
        chk("gap_v2", yv_a, 1);
        chk("gap_y2", y_a, -1);
        tick();
        chk("gap_v3", yv_a, 1);
        chk("gap_y3", y_a, -2);
        tick();
        chk("gap_v_end", yv_a, 0);

        // clr drops the in-flight sample and the history
        x_b = 2'sd1; xv_b = 1'b1; tick();
        xv_b = 1'b0; clr_b = 1'b1; tick();
        clr_b = 1'b0; x_b = 2'sd1; xv_b = 1'b1; tick();
        chk("clr_v0", yv_b, 0);
        x_b = 2'sd0; tick();
        chk("clr_v1", yv_b, 0);
        tick();
        chk("clr_y0", y_b, 1);
        chk("clr_v2", yv_b, 1);
        xv_b = 1'b0; tick();
        chk("clr_y1", y_b, 2);
        tick();
        chk("clr_y2", y_b, 3);
        tick();
        chk("clr_v_end", yv_b, 0);

        // asynchronous reset mid-stream
        load_a(4'sd7, 4'sd7, 4'sd7, 4'sd7);
        x_a = 2'sd1; xv_a = 1'b1;
        tick(); tick(); tick();
        chk("pre_rst_v", yv_a, 1);
        chk("pre_rst_y", y_a, -2);
        chk("pre_rst_s", ys_a, 1);
        #3;
        rst = 1'b1;
        xv_a = 1'b0;
        #1;
        chk("arst_y", y_a, 0);
        chk("arst_v", yv_a, 0);
        chk("arst_s", ys_a, 0);
        #2;
        rst = 1'b0;
        x_a = 2'sd1; xv_a = 1'b1; tick();
        chk("post_rst_v0", yv_a, 0);
        xv_a = 1'b0; tick();
        chk("post_rst_v1", yv_a, 0);
        tick();
        chk("post_rst_v2", yv_a, 1);
        chk("post_rst_y", y_a, 1);
        chk("post_rst_s", ys_a, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
